// File: rtl/ex_pkg.sv
// ex_pkg: opcodes, result selects, constants and FSM encoding shared by the execute stage
package ex_pkg;
   localparam int RegBus    = 32;
   localparam int RegAddBus = 5;
   localparam int AluOpBus  = 8;
   localparam int AluSelBus = 3;
   localparam logic Stop         = 1'b1;
   localparam logic NoStop       = 1'b0;
   localparam logic RstEnable    = 1'b1;
   localparam logic WriteEnable  = 1'b1;
   localparam logic WriteDisable = 1'b0;
   localparam logic [RegBus-1:0]    ZeroWord   = '0;
   localparam logic [RegAddBus-1:0] NOPRegAddr = '0;
   localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
   localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
   localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
   localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
   localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
   localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
   localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
   localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
   localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
   localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
   localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
   localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
   localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
   localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
   localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
   localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
   localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
   localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
   localparam logic [7:0] EXE_ADDI_OP  = 8'b0101_0101;
   localparam logic [7:0] EXE_ADDIU_OP = 8'b0101_0110;
   localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
   localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
   localparam logic [7:0] EXE_MUL_OP   = 8'b1010_1001;
   localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
   localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
   localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
   localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;
   localparam logic [2:0] EXE_RES_NOP        = 3'b000;
   localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
   localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
   localparam logic [2:0] EXE_RES_MOVE       = 3'b011;
   localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;
   localparam logic [2:0] EXE_RES_MUL        = 3'b101;
   typedef enum logic {IDLE, ACC} madd_state_t;
   function automatic logic is_madd(input logic [AluOpBus-1:0] op);
      return op inside {EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP};
   endfunction
endpackage

// File: rtl/ex_mul.sv
// ex_mul: combinational 32x32 -> 64 multiplier, signed or unsigned by signed_i
module ex_mul
   import ex_pkg::*;
(
   input  logic                signed_i,
   input  logic [RegBus-1:0]   a,
   input  logic [RegBus-1:0]   b,
   output logic [2*RegBus-1:0] p
);
   logic [2*RegBus-1:0] ax, bx;
   // low 64 bits of the extended product are the signed product when sign-extended
   assign ax = {{RegBus{signed_i & a[RegBus-1]}}, a};
   assign bx = {{RegBus{signed_i & b[RegBus-1]}}, b};
   assign p  = ax * bx;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS32 execute stage with HI/LO forwarding and a two-cycle multiply-accumulate
module ex_stage
   import ex_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [AluOpBus-1:0]  aluop_i,
   input  logic [AluSelBus-1:0] alusel_i,
   input  logic [RegBus-1:0]    reg1_i,
   input  logic [RegBus-1:0]    reg2_i,
   input  logic [RegAddBus-1:0] wd_i,
   input  logic                 wreg_i,
   input  logic [5:0]           stall,
   input  logic [RegBus-1:0]    hi_i,
   input  logic [RegBus-1:0]    lo_i,
   input  logic                 mem_whilo,
   input  logic [RegBus-1:0]    mem_hi,
   input  logic [RegBus-1:0]    mem_lo,
   input  logic                 wb_whilo,
   input  logic [RegBus-1:0]    wb_hi,
   input  logic [RegBus-1:0]    wb_lo,
   output logic [RegAddBus-1:0] wd_o,
   output logic                 wreg_o,
   output logic [RegBus-1:0]    wdata_o,
   output logic                 whilo_o,
   output logic [RegBus-1:0]    hi_o,
   output logic [RegBus-1:0]    lo_o,
   output logic                 stallreq_o
);
   madd_state_t         state;
   logic [2*RegBus-1:0] prod, mulacc_q, acc_sum;
   logic [RegBus-1:0]   hi_f, lo_f, sum, sra_res, logic_res, shift_res, move_res, arith_res, mul_res;
   logic                madd, acc, mult, is_sub, ov, trap_ov, unused;
   assign hi_f    = mem_whilo ? mem_hi : wb_whilo ? wb_hi : hi_i;
   assign lo_f    = mem_whilo ? mem_lo : wb_whilo ? wb_lo : lo_i;
   assign madd    = is_madd(aluop_i);
   assign acc     = madd && state == ACC;
   assign mult    = aluop_i inside {EXE_MULT_OP, EXE_MULTU_OP};
   assign unused  = ^{stall[5], stall[3:0]};
   ex_mul u_mul (
      .signed_i(aluop_i inside {EXE_MULT_OP, EXE_MUL_OP, EXE_MADD_OP, EXE_MSUB_OP}),
      .a       (reg1_i),
      .b       (reg2_i),
      .p       (prod)
   );
   assign is_sub  = aluop_i inside {EXE_SUB_OP, EXE_SUBU_OP};
   assign sum     = reg1_i + (is_sub ? ~reg2_i : reg2_i) + RegBus'(is_sub);
   assign ov      = (is_sub ? reg1_i[31] != reg2_i[31] : reg1_i[31] == reg2_i[31]) && sum[31] != reg1_i[31];
   assign trap_ov = ov && aluop_i inside {EXE_ADD_OP, EXE_ADDI_OP, EXE_SUB_OP};
   assign sra_res = $signed(reg2_i) >>> reg1_i[4:0];
   assign acc_sum = {hi_f, lo_f} + mulacc_q;
   always_comb begin
      logic_res = aluop_i == EXE_OR_OP  ? reg1_i | reg2_i :
                  aluop_i == EXE_AND_OP ? reg1_i & reg2_i :
                  aluop_i == EXE_XOR_OP ? reg1_i ^ reg2_i :
                  aluop_i == EXE_NOR_OP ? ~(reg1_i | reg2_i) : ZeroWord;
      shift_res = aluop_i == EXE_SLL_OP ? reg2_i << reg1_i[4:0] :
                  aluop_i == EXE_SRL_OP ? reg2_i >> reg1_i[4:0] :
                  aluop_i == EXE_SRA_OP ? sra_res : ZeroWord;
      move_res  = aluop_i == EXE_MFHI_OP ? hi_f : aluop_i == EXE_MFLO_OP ? lo_f : ZeroWord;
      arith_res = aluop_i inside {EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP, EXE_SUB_OP, EXE_SUBU_OP} ? sum :
                  aluop_i == EXE_SLT_OP  ? {31'b0, $signed(reg1_i) < $signed(reg2_i)} :
                  aluop_i == EXE_SLTU_OP ? {31'b0, reg1_i < reg2_i} : ZeroWord;
      mul_res   = aluop_i == EXE_MUL_OP ? prod[RegBus-1:0] : ZeroWord;
   end
   always_comb begin
      wd_o       = rst ? NOPRegAddr : wd_i;
      wreg_o     = rst || trap_ov ? WriteDisable : wreg_i;
      wdata_o    = rst                                ? ZeroWord  :
                   alusel_i == EXE_RES_LOGIC          ? logic_res :
                   alusel_i == EXE_RES_SHIFT          ? shift_res :
                   alusel_i == EXE_RES_MOVE           ? move_res  :
                   alusel_i == EXE_RES_ARITHMETIC     ? arith_res :
                   alusel_i == EXE_RES_MUL            ? mul_res   : ZeroWord;
      whilo_o    = !rst && (madd ? state == ACC : mult || aluop_i inside {EXE_MTHI_OP, EXE_MTLO_OP});
      hi_o       = rst ? ZeroWord : acc ? acc_sum[63:32] : mult ? prod[63:32] :
                   aluop_i == EXE_MTHI_OP ? reg1_i : aluop_i == EXE_MTLO_OP ? hi_f : ZeroWord;
      lo_o       = rst ? ZeroWord : acc ? acc_sum[31:0] : mult ? prod[31:0] :
                   aluop_i == EXE_MTLO_OP ? reg1_i : aluop_i == EXE_MTHI_OP ? lo_f : ZeroWord;
      stallreq_o = !rst && madd && state == IDLE;
   end
   // ACC is left on a non-madd op (flush/bubble) or once EX/MEM accepts the result
   always_ff @(posedge clk)
      if (rst) begin
         state    <= IDLE;
         mulacc_q <= '0;
      end else if (state == IDLE) begin
         if (madd) begin
            state    <= ACC;
            mulacc_q <= aluop_i inside {EXE_MSUB_OP, EXE_MSUBU_OP} ? -prod : prod;
         end
      end else if (!madd || stall[4] == NoStop) state <= IDLE;
endmodule
